divider_seq: RTL and testbench

- Multi-cycle unsigned restoring divider in the execute datapath, next to the combinational ALU.
- Accepts the same 6-bit funct-style Signal code and the dataA/dataB operand pair the ALU consumes.
- Owns the Hi/Lo side of the datapath: produces a 64-bit {remainder, quotient} result after a fixed iteration count.
- A done/busy handshake lets the controller stall until the result is valid.

---
 rtl/divider_seq_if.sv | 24 ++
 rtl/divider_seq.sv | 122 ++++++++++++
 tb/tb_divider_seq.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/divider_seq_if.sv
// Operand/result bundle between the execute-stage controller and divider_seq.
// Handshake: the controller presents Signal with dataA/dataB for one cycle to
// start; busy is high while iterating, done is high while dataOut holds a
// fresh result, and done drops the cycle after a new start is sampled.
interface divider_seq_if #(
   parameter int WIDTH = 32
) ();
   logic [WIDTH-1:0]   dataA;
   logic [WIDTH-1:0]   dataB;
   logic [5:0]         Signal;
   logic [2*WIDTH-1:0] dataOut;
   logic               busy;
   logic               done;

   modport master (
      output dataA, dataB, Signal,
      input  dataOut, busy, done
   );

   modport slave (
      input  dataA, dataB, Signal,
      output dataOut, busy, done
   );
endinterface

// File: rtl/divider_seq.sv
// Multi-cycle restoring divider producing {remainder, quotient} after a fixed
// WIDTH+1 cycle latency (WIDTH restoring steps plus one publish cycle).
// Optional macro SIGNED_DIV_EN: Signal==DIV starts a truncating signed divide;
// without it only unsigned divides (DIVU) exist and DIV is a no-op.
module divider_seq #(
   parameter int         WIDTH = 32,
   parameter logic [5:0] DIVU  = 6'd27,
   parameter logic [5:0] DIV   = 6'd26
) (
   input  logic         clk,
   input  logic         reset,
   divider_seq_if.slave bus,
   output logic [1:0]   fsm_state
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int             CW   = $clog2(WIDTH + 1);
   localparam logic [CW-1:0]  LAST = CW'(WIDTH);

   state_t           state;
   logic [WIDTH-1:0] dq;        // dividend shifting out, quotient shifting in
   logic [WIDTH-1:0] dvs;       // latched divisor magnitude
   logic [WIDTH-1:0] rem;
   logic [CW-1:0]    counter;
   logic             neg_q;     // negate quotient at publish
   logic             neg_r;     // negate remainder at publish

   logic             start_unsigned;
   logic             start_signed;
   logic             start;
   logic [WIDTH-1:0] mag_a;
   logic [WIDTH-1:0] mag_b;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH:0]   rem_sub;
   logic             ge;
   logic [WIDTH-1:0] rem_next;
   logic [WIDTH-1:0] quot_fix;
   logic [WIDTH-1:0] rem_fix;

   assign start_unsigned = (bus.Signal == DIVU);
`ifdef SIGNED_DIV_EN
   assign start_signed   = (bus.Signal == DIV);
`else
   assign start_signed   = 1'b0;
`endif
   assign start = start_unsigned | start_signed;

   // Operand magnitudes; only signed starts see a two's-complement flip.
   assign mag_a = (start_signed && bus.dataA[WIDTH-1]) ? (~bus.dataA + 1'b1) : bus.dataA;
   assign mag_b = (start_signed && bus.dataB[WIDTH-1]) ? (~bus.dataB + 1'b1) : bus.dataB;

   // One restoring step, compared and subtracted at WIDTH+1 bits so the
   // shifted-out top bit of the remainder is never lost.
   assign rem_sh   = {rem, dq[WIDTH-1]};
   assign ge       = (rem_sh >= {1'b0, dvs});
   assign rem_sub  = rem_sh - {1'b0, dvs};
   assign rem_next = ge ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];

   // Sign fix-up: a zero divisor never sets neg_q, and negating the remainder
   // magnitude of a negative dividend restores dataA exactly in that case.
   assign quot_fix = neg_q ? (~dq  + 1'b1) : dq;
   assign rem_fix  = neg_r ? (~rem + 1'b1) : rem;

   assign fsm_state = state;

   // Control FSM and datapath registers with registered handshake outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         dq          <= '0;
         dvs         <= '0;
         rem         <= '0;
         counter     <= '0;
         neg_q       <= 1'b0;
         neg_r       <= 1'b0;
         bus.dataOut <= '0;
         bus.busy    <= 1'b0;
         bus.done    <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state    <= RUN;
                  dq       <= mag_a;
                  dvs      <= mag_b;
                  rem      <= '0;
                  counter  <= '0;
                  neg_q    <= start_signed & (bus.dataA[WIDTH-1] ^ bus.dataB[WIDTH-1])
                              & (|bus.dataB);
                  neg_r    <= start_signed & bus.dataA[WIDTH-1];
                  bus.busy <= 1'b1;
                  bus.done <= 1'b0;
               end
            end
            RUN: begin
               if (counter == LAST) begin
                  // All steps finished: publish the result.
                  bus.dataOut <= {rem_fix, quot_fix};
                  bus.busy    <= 1'b0;
                  bus.done    <= 1'b1;
                  state       <= DONE;
               end else begin
                  rem     <= rem_next;
                  dq      <= {dq[WIDTH-2:0], ge};
                  counter <= counter + 1'b1;
               end
            end
            default: begin
               state    <= IDLE;
               bus.busy <= 1'b0;
               bus.done <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_divider_seq.sv
// Randomized bench for divider_seq against an arithmetic reference model.
module tb_divider_seq;

   localparam int         W       = 32;
   localparam logic [5:0] DIVU    = 6'd27;
   localparam logic [5:0] DIV     = 6'd26;
   localparam int         LAT     = W + 1;
   localparam int         MAX_LAT = 100;

   logic       clk;
   logic       reset;
   logic [1:0] fsm_state;

   int n_checks = 0;
   int n_errors = 0;

   logic [2*W-1:0] exp_q[$];
   logic [2*W-1:0] last_result;

   divider_seq_if #(.WIDTH(W)) bus ();

   divider_seq #(.WIDTH(W), .DIVU(DIVU), .DIV(DIV)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus.slave),
      .fsm_state (fsm_state)
   );

   // Clock and reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [2*W-1:0] got, input logic [2*W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference model: plain integer division at 64 bits.
   function automatic logic [2*W-1:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input bit is_signed);
      longint sa, sb, q, r;
      if (b == '0) return {a, {W{1'b1}}};
      if (!is_signed) return {a % b, a / b};
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      return {r[W-1:0], q[W-1:0]};
   endfunction

   // Drive one operation and follow it to completion. A nonzero intrude_at
   // presents another DIVU at that cycle of the run, which must be ignored.
   task automatic run_div(input logic [5:0] sig, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int intrude_at, input string tag);
      int lat;
      bit busy_ok;
      bit hold_ok;
      bit is_signed;
      logic [2*W-1:0] exp;
`ifdef SIGNED_DIV_EN
      is_signed = (sig == DIV);
`else
      is_signed = 1'b0;
`endif
      exp_q.push_back(ref_div(a, b, is_signed));
      @(negedge clk);
      bus.Signal = sig;
      bus.dataA  = a;
      bus.dataB  = b;
      @(posedge clk);
      #1;
      bus.Signal = 6'd0;
      bus.dataA  = $urandom;
      bus.dataB  = $urandom;
      check({tag, "_start_busy"}, 64'(bus.busy), 64'd1);
      check({tag, "_start_done"}, 64'(bus.done), 64'd0);
      busy_ok = 1'b1;
      hold_ok = 1'b1;
      lat = 0;
      while (lat < MAX_LAT) begin
         if (lat == intrude_at && intrude_at != 0) begin
            bus.Signal = DIVU;
            bus.dataA  = 32'd50;
            bus.dataB  = 32'd3;
         end else begin
            bus.Signal = 6'd0;
         end
         @(posedge clk);
         lat++;
         #1;
         if (bus.done) break;
         if (!bus.busy) busy_ok = 1'b0;
         if (bus.dataOut !== last_result) hold_ok = 1'b0;
      end
      bus.Signal = 6'd0;
      check({tag, "_latency"}, 64'(lat), 64'(LAT));
      check({tag, "_busy_run"}, 64'(busy_ok), 64'd1);
      check({tag, "_hold_old"}, 64'(hold_ok), 64'd1);
      check({tag, "_busy_end"}, 64'(bus.busy), 64'd0);
      exp = exp_q.pop_front();
      check({tag, "_result"}, bus.dataOut, exp);
      last_result = exp;
   endtask

   // Signal codes that are not starts must leave the DONE state untouched.
   task automatic noop_code(input logic [5:0] code);
      @(negedge clk);
      bus.Signal = code;
      bus.dataA  = $urandom;
      bus.dataB  = $urandom;
      @(posedge clk);
      #1;
      bus.Signal = 6'd0;
      check($sformatf("noop%0d_busy", code), 64'(bus.busy), 64'd0);
      check($sformatf("noop%0d_done", code), 64'(bus.done), 64'd1);
      check($sformatf("noop%0d_out", code), bus.dataOut, last_result);
   endtask

   initial begin
      logic [W-1:0] ra, rb;
      logic [5:0] noops[$];
      bus.dataA   = '0;
      bus.dataB   = '0;
      bus.Signal  = 6'd0;
      last_result = '0;
      reset       = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", 64'(bus.busy), 64'd0);
      check("rst_done", 64'(bus.done), 64'd0);
      check("rst_out", bus.dataOut, 64'd0);
      check("rst_state", 64'(fsm_state), 64'd0);
      @(negedge clk);
      reset = 1'b1;

      run_div(DIVU, 32'd100, 32'd7, 0, "d100_7");

      // Abort mid-run with an asynchronous reset.
      @(negedge clk);
      bus.Signal = DIVU;
      bus.dataA  = 32'd1000;
      bus.dataB  = 32'd3;
      @(posedge clk);
      #1;
      bus.Signal = 6'd0;
      repeat (10) @(posedge clk);
      #3;
      reset = 1'b0;
      #1;
      check("midrst_busy", 64'(bus.busy), 64'd0);
      check("midrst_done", 64'(bus.done), 64'd0);
      check("midrst_out", bus.dataOut, 64'd0);
      @(negedge clk);
      reset = 1'b1;
      last_result = '0;
      repeat (40) @(posedge clk);
      #1;
      check("postrst_busy", 64'(bus.busy), 64'd0);
      check("postrst_done", 64'(bus.done), 64'd0);
      check("postrst_out", bus.dataOut, 64'd0);

      // Directed cases; the 9/4 start lands in the DONE cycle of 100/7.
      run_div(DIVU, 32'd100, 32'd7, 0, "d100_7b");
      run_div(DIVU, 32'd9, 32'd4, 0, "b2b_9_4");
      run_div(DIVU, 32'hFFFF_FFFF, 32'd1, 5, "intrude");
      run_div(DIVU, 32'h1234_5678, 32'd0, 0, "divzero");
      run_div(DIVU, 32'd5, 32'd9, 0, "small");

      noops = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42, 6'd0, 6'd63};
`ifndef SIGNED_DIV_EN
      noops.push_back(DIV);
`endif
      foreach (noops[i]) noop_code(noops[i]);

`ifdef SIGNED_DIV_EN
      run_div(DIV, 32'hFFFF_FFF9, 32'd2, 0, "s_m7_2");
      run_div(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, "s_min_m1");
      run_div(DIV, 32'hFFFF_FF00, 32'd0, 0, "s_divzero");
      for (int i = 0; i < 8; i++) begin
         ra = $urandom;
         rb = $urandom_range(0, 3) == 0 ? W'($urandom_range(1, 20)) : $urandom;
         run_div(DIV, ra, rb, 0, $sformatf("s_rand%0d", i));
      end
`endif

      for (int i = 0; i < 20; i++) begin
         ra = $urandom;
         case ($urandom_range(0, 3))
            0:       rb = W'($urandom_range(1, 16));
            1:       rb = ra >> $urandom_range(0, 31);
            default: rb = $urandom;
         endcase
         run_div(DIVU, ra, rb, $urandom_range(0, 1) ? $urandom_range(1, 30) : 0,
                 $sformatf("rand%0d", i));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
